// File: rtl/gfx_pkg.sv
// Shared graphics-path types and defaults for the rectangle fill engine.
package gfx_pkg;

   localparam int GFX_SCREEN_W = 640;
   localparam int GFX_SCREEN_H = 480;
   localparam int GFX_COORD_W  = 11;
   localparam int GFX_COLOR_W  = 1;

   typedef logic [GFX_COORD_W-1:0] coord_t;
   typedef logic [GFX_COLOR_W-1:0] color_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } fill_state_t;

endpackage

// File: rtl/rect_fill_engine_if.sv
// Command and framebuffer-write bundle of the rectangle fill engine.
interface rect_fill_engine_if
   import gfx_pkg::*;
#(
   parameter int COORD_W = GFX_COORD_W,
   parameter int COLOR_W = GFX_COLOR_W
);
   logic               start;
   logic [COORD_W-1:0] x0;
   logic [COORD_W-1:0] y0;
   logic [COORD_W-1:0] x1;
   logic [COORD_W-1:0] y1;
   logic [COLOR_W-1:0] color_in;
   logic               wr_ready;
   logic               wr_en;
   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] y;
   logic [COLOR_W-1:0] color;
   logic               busy;
   logic               done;

   // master is the engine; slave is the requester / framebuffer side
   modport master (
      input  start, x0, y0, x1, y1, color_in, wr_ready,
      output wr_en, x, y, color, busy, done
   );

   modport slave (
      output start, x0, y0, x1, y1, color_in, wr_ready,
      input  wr_en, x, y, color, busy, done
   );
endinterface

// File: rtl/rect_scan_counter.sv
// Two-level nested coordinate counter: inner axis wraps to its low bound and
// bumps the outer axis; last flags the final (x_hi, y_hi) position.
module rect_scan_counter #(
   parameter int COORD_W = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               adv,
   input  logic               inner_is_y,
   input  logic [COORD_W-1:0] x_lo,
   input  logic [COORD_W-1:0] x_hi,
   input  logic [COORD_W-1:0] y_lo,
   input  logic [COORD_W-1:0] y_hi,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               last
);
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic [COORD_W-1:0] x_lo_q, x_lo_d, x_hi_q, x_hi_d;
   logic [COORD_W-1:0] y_lo_q, y_lo_d, y_hi_q, y_hi_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q    <= '0;
         y_q    <= '0;
         x_lo_q <= '0;
         x_hi_q <= '0;
         y_lo_q <= '0;
         y_hi_q <= '0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         x_lo_q <= x_lo_d;
         x_hi_q <= x_hi_d;
         y_lo_q <= y_lo_d;
         y_hi_q <= y_hi_d;
      end
   end

   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      x_lo_d = x_lo_q;
      x_hi_d = x_hi_q;
      y_lo_d = y_lo_q;
      y_hi_d = y_hi_q;
      if (load) begin
         x_lo_d = x_lo;
         x_hi_d = x_hi;
         y_lo_d = y_lo;
         y_hi_d = y_hi;
         x_d    = x_lo;
         y_d    = y_lo;
      end else if (adv) begin
         // adv is never raised on the last pixel, so the outer axis cannot step past its bound
         if (inner_is_y) begin
            if (y_q == y_hi_q) begin
               y_d = y_lo_q;
               x_d = x_q + 1'b1;
            end else begin
               y_d = y_q + 1'b1;
            end
         end else begin
            if (x_q == x_hi_q) begin
               x_d = x_lo_q;
               y_d = y_q + 1'b1;
            end else begin
               x_d = x_q + 1'b1;
            end
         end
      end
   end

   assign x    = x_q;
   assign y    = y_q;
   assign last = (x_q == x_hi_q) && (y_q == y_hi_q);

endmodule

// File: rtl/rect_fill_engine.sv
// Sweeps every pixel of a screen-clipped inclusive rectangle, issuing one
// valid/ready framebuffer write per accepted cycle; busy during, done after.
module rect_fill_engine
   import gfx_pkg::*;
#(
   parameter int SCREEN_W  = GFX_SCREEN_W,
   parameter int SCREEN_H  = GFX_SCREEN_H,
   parameter int COORD_W   = GFX_COORD_W,
   parameter int COLOR_W   = GFX_COLOR_W,
   parameter int ROW_MAJOR = 0
) (
   input logic                clk,
   input logic                reset,
   rect_fill_engine_if.master bus
);
   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_W - 1);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_H - 1);

   fill_state_t state_q, state_d;
   logic [COLOR_W-1:0] color_q, color_d;

   logic [COORD_W-1:0] xa, xb, ya, yb;
   logic               load, empty, adv, last;
   logic               inner_is_y;
   logic [COORD_W-1:0] cnt_x, cnt_y;
   logic               wr_en_o, busy_o, done_o;

   assign xa = (bus.x0 > X_MAX) ? X_MAX : bus.x0;
   assign xb = (bus.x1 > X_MAX) ? X_MAX : bus.x1;
   assign ya = (bus.y0 > Y_MAX) ? Y_MAX : bus.y0;
   assign yb = (bus.y1 > Y_MAX) ? Y_MAX : bus.y1;

   assign load       = (state_q == IDLE) && bus.start;
   assign empty      = (xa > xb) || (ya > yb);
   assign adv        = (state_q == FILL) && bus.wr_ready && !last;
   assign inner_is_y = (ROW_MAJOR == 0);

   rect_scan_counter #(
      .COORD_W (COORD_W)
   ) u_scan (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .adv        (adv),
      .inner_is_y (inner_is_y),
      .x_lo       (xa),
      .x_hi       (xb),
      .y_lo       (ya),
      .y_hi       (yb),
      .x          (cnt_x),
      .y          (cnt_y),
      .last       (last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         color_q <= color_d;
      end
   end

   always_comb begin
      state_d = state_q;
      color_d = color_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               color_d = bus.color_in;
               state_d = empty ? DONE : FILL;
            end
         end
         FILL: begin
            if (bus.wr_ready && last) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_en_o = 1'b0;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         FILL: begin
            wr_en_o = 1'b1;
            busy_o  = 1'b1;
         end
         DONE:    done_o = 1'b1;
         default: ;
      endcase
   end

   assign bus.wr_en = wr_en_o;
   assign bus.busy  = busy_o;
   assign bus.done  = done_o;
   assign bus.x     = cnt_x;
   assign bus.y     = cnt_y;
   assign bus.color = color_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: a 640x480 column-sweep instance and a small
// 48x32 row-major instance, checked against a nested-loop pixel list model.
module tb_rect_fill_engine;
   import gfx_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_r = 1'b1;
   logic        start_r = 1'b0;
   logic        ready_r = 1'b0;
   logic        sel     = 1'b0;
   logic [10:0] x0_r = '0, y0_r = '0, x1_r = '0, y1_r = '0;
   logic        color_r = 1'b0;

   rect_fill_engine_if #(.COORD_W(11), .COLOR_W(1)) if0 ();
   rect_fill_engine_if #(.COORD_W(11), .COLOR_W(1)) if1 ();

   rect_fill_engine #(
      .SCREEN_W(640), .SCREEN_H(480), .COORD_W(11), .COLOR_W(1), .ROW_MAJOR(0)
   ) dut0 (
      .clk(clk), .reset(reset_r), .bus(if0)
   );

   rect_fill_engine #(
      .SCREEN_W(48), .SCREEN_H(32), .COORD_W(11), .COLOR_W(1), .ROW_MAJOR(1)
   ) dut1 (
      .clk(clk), .reset(reset_r), .bus(if1)
   );

   assign if0.start    = start_r & (sel == 1'b0);
   assign if1.start    = start_r & (sel == 1'b1);
   assign if0.x0       = x0_r;
   assign if0.y0       = y0_r;
   assign if0.x1       = x1_r;
   assign if0.y1       = y1_r;
   assign if0.color_in = color_r;
   assign if0.wr_ready = ready_r;
   assign if1.x0       = x0_r;
   assign if1.y0       = y0_r;
   assign if1.x1       = x1_r;
   assign if1.y1       = y1_r;
   assign if1.color_in = color_r;
   assign if1.wr_ready = ready_r;

   logic        cw_en, cbusy, cdone;
   logic [10:0] cx, cy;
   logic        cc;
   assign cw_en = sel ? if1.wr_en : if0.wr_en;
   assign cbusy = sel ? if1.busy  : if0.busy;
   assign cdone = sel ? if1.done  : if0.done;
   assign cx    = sel ? if1.x     : if0.x;
   assign cy    = sel ? if1.y     : if0.y;
   assign cc    = sel ? if1.color : if0.color;

   int checks   = 0;
   int failures = 0;
   int got_x[$], got_y[$], got_c[$];
   int exp_x[$], exp_y[$];
   int first_wr, done_idx, last_acc, hold_err, post_err, done_busy_err;
   bit timed_out;
   bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   // Reference: clip to the screen, then list pixels outer-by-inner.
   task automatic build_model(input int s, input int x0, input int y0, input int x1, input int y1);
      int sw, sh, xa, xb, ya, yb;
      sw = (s == 1) ? 48 : 640;
      sh = (s == 1) ? 32 : 480;
      xa = (x0 < sw - 1) ? x0 : sw - 1;
      xb = (x1 < sw - 1) ? x1 : sw - 1;
      ya = (y0 < sh - 1) ? y0 : sh - 1;
      yb = (y1 < sh - 1) ? y1 : sh - 1;
      exp_x.delete();
      exp_y.delete();
      if (s == 0) begin
         for (int a = xa; a <= xb; a++)
            for (int b = ya; b <= yb; b++) begin exp_x.push_back(a); exp_y.push_back(b); end
      end else begin
         for (int b = ya; b <= yb; b++)
            for (int a = xa; a <= xb; a++) begin exp_x.push_back(a); exp_y.push_back(b); end
      end
   endtask

   task automatic run_fill(input int s, input int x0, input int y0, input int x1, input int y1,
                           input logic c, input int rmode, input int inj_at, input bit inj_done,
                           input int budget);
      bit prev_stall;
      logic [10:0] px, py;
      logic pc;
      sel = s[0];
      x0_r = 11'(x0); y0_r = 11'(y0); x1_r = 11'(x1); y1_r = 11'(y1);
      color_r = c;
      ready_r = 1'b1;
      start_r = 1'b1;
      @(negedge clk);
      start_r = 1'b0;
      build_model(s, x0, y0, x1, y1);
      got_x.delete(); got_y.delete(); got_c.delete();
      first_wr = -1; done_idx = -1; last_acc = -1;
      hold_err = 0; post_err = 0; done_busy_err = 0;
      prev_stall = 1'b0; px = '0; py = '0; pc = 1'b0;
      for (int cyc = 0; cyc < budget && done_idx < 0; cyc++) begin
         start_r = 1'b0;
         if (cyc == inj_at) begin
            start_r = 1'b1;
            x0_r = 11'd0; y0_r = 11'd0; x1_r = 11'd30; y1_r = 11'd30;
            color_r = ~c;
         end
         case (rmode)
            0:       ready_r = 1'b1;
            1:       ready_r = 1'($urandom_range(0, 1));
            default: ready_r = pat[cyc % 6];
         endcase
         if (prev_stall && (cw_en !== 1'b1 || cx !== px || cy !== py || cc !== pc)) hold_err++;
         if (cw_en === 1'b1 && first_wr < 0) first_wr = cyc;
         if (cw_en === 1'b1 && ready_r) begin
            got_x.push_back(int'(cx));
            got_y.push_back(int'(cy));
            got_c.push_back(int'(cc));
            last_acc = cyc;
         end
         prev_stall = (cw_en === 1'b1) && !ready_r;
         px = cx; py = cy; pc = cc;
         if (cdone === 1'b1) begin
            done_idx = cyc;
            if (cbusy !== 1'b0 || cw_en !== 1'b0) done_busy_err++;
            if (inj_done) begin
               start_r = 1'b1;
               x0_r = 11'd1; y0_r = 11'd1; x1_r = 11'd3; y1_r = 11'd3;
            end
         end
         @(negedge clk);
      end
      timed_out = (done_idx < 0);
      for (int k = 0; k < 3; k++) begin
         start_r = 1'b0;
         if (cdone !== 1'b0 || cw_en !== 1'b0 || cbusy !== 1'b0) post_err++;
         @(negedge clk);
      end
      $display("fill dut%0d (%0d,%0d)-(%0d,%0d) color=%0d ready_mode=%0d writes=%0d expected=%0d done_at=%0d",
               s, x0, y0, x1, y1, c, rmode, got_x.size(), exp_x.size(), done_idx);
   endtask

   // A single fill scenario: stimulus plus every generic property of the result.
   task automatic test_fill(input int s, input int x0, input int y0, input int x1, input int y1,
                            input logic c, input int rmode, input int inj_at, input bit inj_done,
                            input int budget);
      int mism, cmism, fi;
      run_fill(s, x0, y0, x1, y1, c, rmode, inj_at, inj_done, budget);
      checks++;
      if (timed_out) begin
         failures++;
         $display("FAIL done_timeout dut%0d: no done within %0d cycles", s, budget);
      end
      checks++;
      if (got_x.size() !== exp_x.size()) begin
         failures++;
         $display("FAIL write_count dut%0d: got %0d expected %0d", s, got_x.size(), exp_x.size());
      end
      mism = 0; cmism = 0; fi = -1;
      for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
         if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
            mism++;
            if (fi < 0) fi = i;
         end
         if (got_c[i] != int'(c)) cmism++;
      end
      checks++;
      if (mism !== 0) begin
         failures++;
         $display("FAIL pixel_order dut%0d: %0d wrong, first at #%0d got (%0d,%0d) expected (%0d,%0d)",
                  s, mism, fi, got_x[fi], got_y[fi], exp_x[fi], exp_y[fi]);
      end
      checks++;
      if (cmism !== 0) begin
         failures++;
         $display("FAIL pixel_color dut%0d: %0d writes not color %0d", s, cmism, c);
      end
      checks++;
      if (first_wr !== ((exp_x.size() > 0) ? 0 : -1)) begin
         failures++;
         $display("FAIL first_write_latency dut%0d: got cycle %0d expected %0d", s, first_wr,
                  (exp_x.size() > 0) ? 0 : -1);
      end
      checks++;
      if (done_idx !== last_acc + 1) begin
         failures++;
         $display("FAIL done_timing dut%0d: done at %0d expected %0d", s, done_idx, last_acc + 1);
      end
      checks++;
      if (hold_err !== 0) begin
         failures++;
         $display("FAIL stall_hold dut%0d: %0d cycles changed while stalled, expected 0", s, hold_err);
      end
      checks++;
      if (done_busy_err !== 0 || post_err !== 0) begin
         failures++;
         $display("FAIL done_pulse dut%0d: done-cycle errors %0d, post-done errors %0d, expected 0 and 0",
                  s, done_busy_err, post_err);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({if0.wr_en, if0.busy, if0.done, if0.color} !== 4'b0 || if0.x !== 11'd0 || if0.y !== 11'd0) begin
         failures++;
         $display("FAIL reset_dut0: wr_en=%b busy=%b done=%b color=%b x=%0d y=%0d, expected all 0",
                  if0.wr_en, if0.busy, if0.done, if0.color, if0.x, if0.y);
      end
      checks++;
      if ({if1.wr_en, if1.busy, if1.done, if1.color} !== 4'b0 || if1.x !== 11'd0 || if1.y !== 11'd0) begin
         failures++;
         $display("FAIL reset_dut1: wr_en=%b busy=%b done=%b color=%b x=%0d y=%0d, expected all 0",
                  if1.wr_en, if1.busy, if1.done, if1.color, if1.x, if1.y);
      end
      reset_r = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_clear();
      test_fill(1, 0, 0, 47, 31, 1'b1, 0, -1, 1'b0, 4000);
      test_fill(0, 0, 0, 19, 479, 1'b0, 0, -1, 1'b0, 12000);
      checks++;
      if (got_x.size() < 9600 || got_x[1] !== 0 || got_y[1] !== 1 || got_x[480] !== 1 || got_y[480] !== 0 ||
          got_x[9599] !== 19 || got_y[9599] !== 479) begin
         failures++;
         $display("FAIL column_landmarks: size=%0d, expected 2nd=(0,1) 481st=(1,0) last=(19,479)", got_x.size());
      end
   endtask

   task automatic test_order();
      int ex0 [4] = '{2, 2, 3, 3};
      int ey0 [4] = '{3, 4, 3, 4};
      int ex1 [4] = '{2, 3, 2, 3};
      int ey1 [4] = '{3, 3, 4, 4};
      int bad;
      test_fill(0, 2, 3, 3, 4, 1'b1, 0, -1, 1'b0, 50);
      bad = (got_x.size() != 4) ? 1 : 0;
      for (int i = 0; i < 4 && i < got_x.size(); i++)
         if (got_x[i] != ex0[i] || got_y[i] != ey0[i] || got_c[i] != 1) bad++;
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL order_column: %0d deviations, expected (2,3),(2,4),(3,3),(3,4)", bad);
      end
      test_fill(1, 2, 3, 3, 4, 1'b1, 0, -1, 1'b0, 50);
      bad = (got_x.size() != 4) ? 1 : 0;
      for (int i = 0; i < 4 && i < got_x.size(); i++)
         if (got_x[i] != ex1[i] || got_y[i] != ey1[i] || got_c[i] != 1) bad++;
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL order_row: %0d deviations, expected (2,3),(3,3),(2,4),(3,4)", bad);
      end
   endtask

   task automatic test_stall();
      test_fill(0, 2, 3, 3, 4, 1'b1, 2, -1, 1'b0, 100);
      test_fill(1, 10, 5, 14, 7, 1'b0, 1, -1, 1'b0, 500);
   endtask

   task automatic test_clip_empty();
      int mx, my;
      test_fill(0, 600, 470, 700, 500, 1'b1, 0, -1, 1'b0, 1000);
      mx = 0; my = 0;
      foreach (got_x[i]) begin
         if (got_x[i] > mx) mx = got_x[i];
         if (got_y[i] > my) my = got_y[i];
      end
      checks++;
      if (got_x.size() !== 400 || mx !== 639 || my !== 479) begin
         failures++;
         $display("FAIL clip_bounds: writes=%0d max_x=%0d max_y=%0d, expected 400 639 479", got_x.size(), mx, my);
      end
      test_fill(0, 5, 5, 4, 9, 1'b0, 0, -1, 1'b0, 20);
      test_fill(1, 60, 2, 70, 4, 1'b1, 0, -1, 1'b0, 20);
   endtask

   task automatic test_ignore_start();
      test_fill(0, 10, 10, 14, 13, 1'b1, 0, 5, 1'b1, 200);
      test_fill(1, 3, 3, 9, 5, 1'b0, 1, 7, 1'b1, 400);
   endtask

   task automatic test_reset_mid_fill();
      int acc, dn;
      sel = 1'b0;
      x0_r = 11'd0; y0_r = 11'd0; x1_r = 11'd9; y1_r = 11'd9; color_r = 1'b1;
      ready_r = 1'b1;
      start_r = 1'b1;
      @(negedge clk);
      start_r = 1'b0;
      acc = 0;
      for (int cyc = 0; cyc < 50 && acc < 10; cyc++) begin
         if (if0.wr_en === 1'b1) acc++;
         @(negedge clk);
      end
      reset_r = 1'b1;
      @(negedge clk);
      $display("reset after %0d writes: wr_en=%b busy=%b x=%0d y=%0d", acc, if0.wr_en, if0.busy, if0.x, if0.y);
      checks++;
      if (acc !== 10 || {if0.wr_en, if0.busy, if0.done} !== 3'b0 || if0.x !== 11'd0 || if0.y !== 11'd0) begin
         failures++;
         $display("FAIL reset_abort: writes=%0d wr_en=%b busy=%b done=%b x=%0d y=%0d, expected 10 0 0 0 0 0",
                  acc, if0.wr_en, if0.busy, if0.done, if0.x, if0.y);
      end
      reset_r = 1'b0;
      dn = 0;
      for (int k = 0; k < 4; k++) begin
         if (if0.done !== 1'b0 || if0.wr_en !== 1'b0) dn++;
         @(negedge clk);
      end
      checks++;
      if (dn !== 0) begin
         failures++;
         $display("FAIL reset_no_done: %0d cycles with done or wr_en after abort, expected 0", dn);
      end
      test_fill(0, 1, 2, 4, 6, 1'b1, 1, -1, 1'b0, 300);
   endtask

   task automatic test_random();
      int s, sw, sh, x0, y0, x1, y1;
      for (int n = 0; n < 12; n++) begin
         s  = int'($urandom_range(0, 1));
         sw = (s == 1) ? 48 : 640;
         sh = (s == 1) ? 32 : 480;
         x0 = int'($urandom_range(0, sw + 4));
         y0 = int'($urandom_range(0, sh + 4));
         x1 = x0 + int'($urandom_range(0, 9)) - 2;
         y1 = y0 + int'($urandom_range(0, 9)) - 2;
         if (x1 < 0) x1 = 0;
         if (y1 < 0) y1 = 0;
         test_fill(s, x0, y0, x1, y1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), -1, 1'b0, 1000);
      end
   endtask

   initial begin
      test_reset();
      test_full_clear();
      test_order();
      test_stall();
      test_clip_empty();
      test_ignore_start();
      test_reset_mid_fill();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
